shot_sequencer: RTL

SHOT_SEQUENCER -- requirements
Module: shot_sequencer

---
 rtl/shot_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/shot_sequencer.sv
// Shot sequencer: per-shot trig, acquisition window and accumulator clear for an nshot run; all outputs registered.
// Trig follows an accepted start by one cycle; SHOT_SEQUENCER_EXTTRIG_EN also gates each later trig on an external edge.
module shot_sequencer #(
   parameter int NSHOTWIDTH = 16,
   parameter int TWIDTH     = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stb_start,
   input  logic                  stb_abort,
   input  logic [NSHOTWIDTH-1:0] nshot,
   input  logic [TWIDTH-1:0]     delayaftertrig,
   input  logic [TWIDTH-1:0]     acqlen,
   input  logic [TWIDTH-1:0]     period,
   input  logic                  resetacc,
`ifdef SHOT_SEQUENCER_EXTTRIG_EN
   input  logic                  exttrig,
`endif
   output logic                  trig,
   output logic                  acqwin,
   output logic                  accclr,
   output logic [NSHOTWIDTH-1:0] shotcnt,
   output logic                  lastshotdone,
   output logic                  busy
);

   typedef enum logic [2:0] {IDLE, TRIG, DELAY, ACQ, GAP} state_t;

   localparam int XW = TWIDTH + 2;

   state_t                  state, state_nxt;
   logic [TWIDTH-1:0]       tmr, tmr_nxt, tmr_inc;
   logic [NSHOTWIDTH-1:0]   nshot_l;
   logic [TWIDTH-1:0]       dly_l, len_l, per_l;
   logic [NSHOTWIDTH-1:0]   shotcnt_nxt;
   logic                    lsd_nxt, accclr_nxt, latch_en;
   logic [XW-1:0]           acq_end_w, min_per_w, per_w, gap_end_w;
   logic [TWIDTH-1:0]       acq_end, gap_end;
   logic                    ext_ok;

   function automatic logic [TWIDTH-1:0] sat_t(input logic [XW-1:0] v);
      return (|v[XW-1:TWIDTH]) ? {TWIDTH{1'b1}} : v[TWIDTH-1:0];
   endfunction

   // Phase boundaries measured from the trig cycle (timer = 0 there).
   always_comb begin
      acq_end_w = {2'b00, dly_l} + {2'b00, len_l};
      min_per_w = acq_end_w + XW'(2);
      per_w     = ({2'b00, per_l} > min_per_w) ? {2'b00, per_l} : min_per_w;
      gap_end_w = per_w - XW'(1);
      acq_end   = sat_t(acq_end_w);
      gap_end   = sat_t(gap_end_w);
      tmr_inc   = (&tmr) ? tmr : tmr + TWIDTH'(1);
   end

`ifdef SHOT_SEQUENCER_EXTTRIG_EN
   logic [2:0] ext_sync;
   logic       ext_edge;
   logic       ext_seen;

   assign ext_edge = ext_sync[1] & ~ext_sync[2];
   assign ext_ok   = ext_seen | ext_edge;

   // An edge only counts while waiting in GAP; anything earlier is discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         ext_sync <= '0;
         ext_seen <= 1'b0;
      end else begin
         ext_sync <= {ext_sync[1:0], exttrig};
         ext_seen <= (state == GAP) && (state_nxt == GAP) && (ext_seen || ext_edge);
      end
   end
`else
   assign ext_ok = 1'b1;
`endif

   always_comb begin
      state_nxt   = state;
      tmr_nxt     = tmr_inc;
      shotcnt_nxt = shotcnt;
      lsd_nxt     = lastshotdone;
      accclr_nxt  = 1'b0;
      latch_en    = 1'b0;
      case (state)
         IDLE: begin
            tmr_nxt = '0;
            if (stb_start && !stb_abort && (nshot != '0)) begin
               latch_en    = 1'b1;
               state_nxt   = TRIG;
               shotcnt_nxt = '0;
               lsd_nxt     = 1'b0;
               accclr_nxt  = resetacc;
            end
         end
         TRIG: state_nxt = (dly_l == '0) ? ACQ : DELAY;
         DELAY: begin
            if (tmr >= dly_l) state_nxt = ACQ;
         end
         ACQ: begin
            if (tmr >= acq_end) begin
               state_nxt   = GAP;
               shotcnt_nxt = shotcnt + NSHOTWIDTH'(1);
            end
         end
         GAP: begin
            if (shotcnt == nshot_l) begin
               state_nxt = IDLE;
               lsd_nxt   = 1'b1;
            end else if ((tmr >= gap_end) && ext_ok) begin
               state_nxt = TRIG;
               tmr_nxt   = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if ((state != IDLE) && stb_abort) begin
         state_nxt   = IDLE;
         shotcnt_nxt = shotcnt;
         lsd_nxt     = lastshotdone;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         tmr          <= '0;
         nshot_l      <= '0;
         dly_l        <= '0;
         len_l        <= '0;
         per_l        <= '0;
         shotcnt      <= '0;
         lastshotdone <= 1'b0;
         accclr       <= 1'b0;
         trig         <= 1'b0;
         acqwin       <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nxt;
         tmr          <= tmr_nxt;
         shotcnt      <= shotcnt_nxt;
         lastshotdone <= lsd_nxt;
         accclr       <= accclr_nxt;
         trig         <= (state_nxt == TRIG);
         acqwin       <= (state_nxt == ACQ);
         busy         <= (state_nxt != IDLE);
         if (latch_en) begin
            nshot_l <= nshot;
            dly_l   <= delayaftertrig;
            len_l   <= (acqlen == '0) ? TWIDTH'(1) : acqlen;
            per_l   <= period;
         end
      end
   end

endmodule
